seven_segment_reader: RTL

SEVEN_SEGMENT_READER -- requirements
Module: seven_segment_reader

---
 rtl/seven_segment_reader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seven_segment_reader.sv
// Debounces a 7-segment pattern and emits one decoded token per newly accepted
// pattern through a single-entry valid/ready output register.
module seven_segment_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] io_segIn,
    output logic       io_out_valid,
    input  logic       io_out_ready,
    output logic [3:0] io_out_bits_value,
    output logic       io_out_bits_blank,
    output logic       io_out_bits_error,
    output logic       io_stable,
    output logic [7:0] io_dropCount
);

    localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

    typedef enum logic {SETTLE, LOCKED} state_t;

    state_t     state_q, state_d;
    logic [6:0] s_q, s_d;
    logic [6:0] cand_q, cand_d;
    logic [6:0] last_acc_q, last_acc_d;
    logic [7:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;
    logic [3:0] value_q, value_d;
    logic       blank_q, blank_d;
    logic       error_q, error_d;
    logic [7:0] drop_q, drop_d;

    logic       push;
    logic [3:0] dec_value;
    logic       dec_blank;
    logic       dec_error;

    always_comb begin
        dec_value = 4'd0;
        dec_blank = 1'b0;
        dec_error = 1'b0;
        case (cand_q)
            7'h7E: dec_value = 4'd0;
            7'h30: dec_value = 4'd1;
            7'h6D: dec_value = 4'd2;
            7'h79: dec_value = 4'd3;
            7'h33: dec_value = 4'd4;
            7'h5B: dec_value = 4'd5;
            7'h5F: dec_value = 4'd6;
            7'h70: dec_value = 4'd7;
            7'h7F: dec_value = 4'd8;
            7'h7B: dec_value = 4'd9;
            7'h00: dec_blank = 1'b1;
            default: dec_error = 1'b1;
        endcase
    end

    // Debounce: any change restarts settling; acceptance only re-emits a pattern
    // that differs from the last accepted one.
    always_comb begin
        s_d        = io_segIn;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        last_acc_d = last_acc_q;
        state_d    = state_q;
        push       = 1'b0;
        if (s_q != cand_q) begin
            cand_d  = s_q;
            cnt_d   = 8'd1;
            state_d = SETTLE;
        end else if (state_q == SETTLE) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == STABLE_N) begin
                last_acc_d = cand_q;
                state_d    = LOCKED;
                push       = (cand_q != last_acc_q);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        value_d = value_q;
        blank_d = blank_q;
        error_d = error_q;
        drop_d  = drop_q;
        if (push) begin
            if (!valid_q || io_out_ready) begin
                valid_d = 1'b1;
                value_d = dec_value;
                blank_d = dec_blank;
                error_d = dec_error;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (valid_q && io_out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= SETTLE;
            s_q        <= 7'h00;
            cand_q     <= 7'h00;
            last_acc_q <= 7'h00;
            cnt_q      <= 8'd0;
            valid_q    <= 1'b0;
            value_q    <= 4'd0;
            blank_q    <= 1'b0;
            error_q    <= 1'b0;
            drop_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            cand_q     <= cand_d;
            last_acc_q <= last_acc_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            value_q    <= value_d;
            blank_q    <= blank_d;
            error_q    <= error_d;
            drop_q     <= drop_d;
        end
    end

    assign io_out_valid      = valid_q;
    assign io_out_bits_value = value_q;
    assign io_out_bits_blank = blank_q;
    assign io_out_bits_error = error_q;
    assign io_stable         = (state_q == LOCKED);
    assign io_dropCount      = drop_q;

endmodule
